// File: rtl/floor_request_scheduler_if.sv
// Signal bundle between the elevator controller (master) and the floor request
// scheduler (slave).
interface floor_request_scheduler_if #(
  parameter int NFLOORS = 8,
  parameter int FW      = 3
);
  // tgt_floor is meaningful only while tgt_valid=1; the controller acknowledges
  // arrival with a one-cycle served pulse qualified by cur_floor, which retires
  // req_pending[cur_floor]. There is no back-pressure in either direction.
  logic [NFLOORS-1:0] btn_in;
  logic [FW-1:0]      cur_floor;
  logic               served;
  logic [NFLOORS-1:0] req_pending;
  logic [FW-1:0]      tgt_floor;
  logic               tgt_valid;
  logic               dir_up;
  logic               dir_down;
  logic [1:0]         state_dbg;

  modport master (
    output btn_in, cur_floor, served,
    input  req_pending, tgt_floor, tgt_valid, dir_up, dir_down, state_dbg
  );

  modport slave (
    input  btn_in, cur_floor, served,
    output req_pending, tgt_floor, tgt_valid, dir_up, dir_down, state_dbg
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// Floor call front end: synchronise and debounce buttons, latch requests until
// served, and pick the next target floor with a SCAN-style direction FSM.
module floor_request_scheduler #(
  parameter int NFLOORS    = 8,
  parameter int FW         = 3,
  parameter int DEB_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  floor_request_scheduler_if.slave bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  logic [NFLOORS-1:0] sync1, sync2;
  logic [NFLOORS-1:0] deb, deb_nxt;
  logic [CW-1:0]      cnt     [NFLOORS];
  logic [CW-1:0]      cnt_nxt [NFLOORS];
  logic [NFLOORS-1:0] rise;
  logic [NFLOORS-1:0] clr_mask;
  logic [NFLOORS-1:0] req, req_nxt;

  state_t             state, state_nxt;
  logic [FW-1:0]      tgt_q, tgt_nxt;
  logic               valid_q;
  logic               above, below, here;
  logic [FW-1:0]      lo_tgt, hi_tgt;

  // The debounced level toggles on the edge the counter would reach DEB_CYCLES.
  always_comb begin
    deb_nxt = deb;
    rise    = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = ~deb[i];
          rise[i]    = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear is applied after set so a coincident serve of the same floor wins.
  always_comb begin
    clr_mask = bus.served ? (NFLOORS'(1) << bus.cur_floor) : '0;
    req_nxt  = (req | rise) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      req   <= '0;
      for (int i = 0; i < NFLOORS; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.btn_in;
      sync2 <= sync1;
      deb   <= deb_nxt;
      req   <= req_nxt;
      for (int i = 0; i < NFLOORS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    above  = 1'b0;
    below  = 1'b0;
    here   = req[bus.cur_floor];
    lo_tgt = tgt_q;
    hi_tgt = tgt_q;
    for (int i = 0; i < NFLOORS; i++) begin
      if (FW'(i) > bus.cur_floor) above = above | req[i];
      if (FW'(i) < bus.cur_floor) below = below | req[i];
    end
    // Lowest pending at or above, highest pending at or below the car.
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (req[i] && (FW'(i) >= bus.cur_floor)) lo_tgt = FW'(i);
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (req[i] && (FW'(i) <= bus.cur_floor)) hi_tgt = FW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    case (state)
      S_IDLE: begin
        if (above)      state_nxt = S_UP;
        else if (below) state_nxt = S_DOWN;
        else            state_nxt = S_IDLE;
      end
      S_UP: begin
        if (above || here) state_nxt = S_UP;
        else if (below)    state_nxt = S_DOWN;
        else               state_nxt = S_IDLE;
      end
      S_DOWN: begin
        if (below || here) state_nxt = S_DOWN;
        else if (above)    state_nxt = S_UP;
        else               state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_UP:    tgt_nxt = lo_tgt;
      S_DOWN:  tgt_nxt = hi_tgt;
      default: tgt_nxt = here ? bus.cur_floor : tgt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tgt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      tgt_q   <= tgt_nxt;
      valid_q <= |req;
    end
  end

  assign bus.req_pending = req;
  assign bus.tgt_floor   = tgt_q;
  assign bus.tgt_valid   = valid_q;
  assign bus.dir_up      = (state == S_UP);
  assign bus.dir_down    = (state == S_DOWN);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler: debounce latency, glitch rejection,
// SCAN direction/target selection, serve/set collision and asynchronous reset.
module tb_floor_request_scheduler;

  localparam int NFLOORS = 8;
  localparam int FW      = 3;
  localparam int DEB     = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  floor_request_scheduler_if #(.NFLOORS(NFLOORS), .FW(FW)) bus ();

  floor_request_scheduler #(
    .NFLOORS   (NFLOORS),
    .FW        (FW),
    .DEB_CYCLES(DEB)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [FW-1:0] floor);
    bus.cur_floor = floor;
    bus.served    = 1'b1;
    tick();
    bus.served    = 1'b0;
  endtask

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.btn_in    = '0;
    bus.cur_floor = '0;
    bus.served    = 1'b0;
    repeat (3) tick();
    check_eq("rst_req",   32'(bus.req_pending), 32'h00);
    check_eq("rst_tgt",   32'(bus.tgt_floor),   32'h0);
    check_eq("rst_valid", 32'(bus.tgt_valid),   32'h0);
    check_eq("rst_up",    32'(bus.dir_up),      32'h0);
    check_eq("rst_down",  32'(bus.dir_down),    32'h0);
    rst = 1'b1;
    repeat (2) tick();

    // 1: debounce latency and first target
    bus.cur_floor = 3'd0;
    bus.btn_in    = 8'h04;
    repeat (5) tick();
    check_eq("t1_req_early", 32'(bus.req_pending), 32'h00);
    tick();
    check_eq("t1_req",       32'(bus.req_pending), 32'h04);
    check_eq("t1_valid_lag", 32'(bus.tgt_valid),   32'h0);
    tick();
    check_eq("t1_tgt",   32'(bus.tgt_floor), 32'h2);
    check_eq("t1_valid", 32'(bus.tgt_valid), 32'h1);
    check_eq("t1_up",    32'(bus.dir_up),    32'h1);
    check_eq("t1_down",  32'(bus.dir_down),  32'h0);
    repeat (5) tick();
    bus.btn_in = 8'h00;
    serve(3'd2);
    check_eq("t1_req_clr", 32'(bus.req_pending), 32'h00);
    tick();
    check_eq("t1_idle_valid", 32'(bus.tgt_valid), 32'h0);
    check_eq("t1_idle_up",    32'(bus.dir_up),    32'h0);
    check_eq("t1_tgt_hold",   32'(bus.tgt_floor), 32'h2);
    check_eq("t1_state",      32'(bus.state_dbg), 32'h0);
    repeat (8) tick();

    // 2: short pulses are rejected
    for (int k = 0; k < 3; k++) begin
      bus.btn_in = 8'h20;
      repeat (2) tick();
      bus.btn_in = 8'h00;
      repeat (2) tick();
      check_eq("t2_req", 32'(bus.req_pending), 32'h00);
    end
    repeat (6) tick();
    check_eq("t2_req_end", 32'(bus.req_pending), 32'h00);
    check_eq("t2_valid",   32'(bus.tgt_valid),   32'h0);

    // 3: up sweep, reversal, idle
    bus.cur_floor = 3'd3;
    bus.btn_in    = 8'h42;
    repeat (6) tick();
    check_eq("t3_req", 32'(bus.req_pending), 32'h42);
    tick();
    bus.btn_in = 8'h00;
    check_eq("t3_up",  32'(bus.dir_up),    32'h1);
    check_eq("t3_tgt", 32'(bus.tgt_floor), 32'h6);
    serve(3'd6);
    check_eq("t3_req6", 32'(bus.req_pending), 32'h02);
    tick();
    check_eq("t3_down",     32'(bus.dir_down),  32'h1);
    check_eq("t3_down_up",  32'(bus.dir_up),    32'h0);
    check_eq("t3_tgt_down", 32'(bus.tgt_floor), 32'h1);
    serve(3'd1);
    tick();
    check_eq("t3_valid", 32'(bus.tgt_valid), 32'h0);
    check_eq("t3_up0",   32'(bus.dir_up),    32'h0);
    check_eq("t3_down0", 32'(bus.dir_down),  32'h0);
    repeat (8) tick();

    // 4: retarget to a nearer request, no reversal while above remains
    bus.cur_floor = 3'd2;
    bus.btn_in    = 8'hA0;
    repeat (6) tick();
    check_eq("t4_req", 32'(bus.req_pending), 32'hA0);
    bus.btn_in = 8'h00;
    tick();
    check_eq("t4_up",   32'(bus.dir_up),    32'h1);
    check_eq("t4_tgt5", 32'(bus.tgt_floor), 32'h5);
    bus.btn_in = 8'h10;
    repeat (6) tick();
    check_eq("t4_req4", 32'(bus.req_pending), 32'hB0);
    tick();
    check_eq("t4_tgt4", 32'(bus.tgt_floor), 32'h4);
    bus.btn_in = 8'h02;
    repeat (6) tick();
    bus.btn_in = 8'h00;
    check_eq("t4_req1",  32'(bus.req_pending), 32'hB2);
    check_eq("t4_up1",   32'(bus.dir_up),      32'h1);
    check_eq("t4_down1", 32'(bus.dir_down),    32'h0);
    serve(3'd4);
    check_eq("t4_req_s4", 32'(bus.req_pending), 32'hA2);
    tick();
    check_eq("t4_tgt_s4", 32'(bus.tgt_floor), 32'h5);
    check_eq("t4_up_s4",  32'(bus.dir_up),    32'h1);
    serve(3'd5);
    check_eq("t4_req_s5", 32'(bus.req_pending), 32'h82);
    tick();
    check_eq("t4_tgt_s5", 32'(bus.tgt_floor), 32'h7);
    serve(3'd7);
    check_eq("t4_req_s7", 32'(bus.req_pending), 32'h02);
    tick();
    check_eq("t4_down_s7", 32'(bus.dir_down),  32'h1);
    check_eq("t4_tgt_s7",  32'(bus.tgt_floor), 32'h1);
    serve(3'd1);
    tick();
    check_eq("t4_state_end", 32'(bus.state_dbg), 32'h0);
    repeat (8) tick();

    // 5: serve coincides with the rise of floor 3; floor 0 still latches
    bus.cur_floor = 3'd3;
    bus.btn_in    = 8'h09;
    repeat (5) tick();
    bus.served = 1'b1;
    tick();
    bus.served = 1'b0;
    check_eq("t5_req", 32'(bus.req_pending), 32'h01);
    tick();
    bus.btn_in = 8'h00;
    check_eq("t5_down", 32'(bus.dir_down),  32'h1);
    check_eq("t5_tgt",  32'(bus.tgt_floor), 32'h0);
    serve(3'd0);
    check_eq("t5_req_clr", 32'(bus.req_pending), 32'h00);
    tick();
    check_eq("t5_valid", 32'(bus.tgt_valid), 32'h0);
    repeat (8) tick();

    // 6: asynchronous reset mid-operation
    bus.cur_floor = 3'd0;
    bus.btn_in    = 8'h44;
    repeat (6) tick();
    check_eq("t6_req", 32'(bus.req_pending), 32'h44);
    tick();
    check_eq("t6_up", 32'(bus.dir_up), 32'h1);
    #3;
    rst = 1'b0;
    #1;
    check_eq("t6_rst_req",   32'(bus.req_pending), 32'h00);
    check_eq("t6_rst_tgt",   32'(bus.tgt_floor),   32'h0);
    check_eq("t6_rst_valid", 32'(bus.tgt_valid),   32'h0);
    check_eq("t6_rst_up",    32'(bus.dir_up),      32'h0);
    check_eq("t6_rst_down",  32'(bus.dir_down),    32'h0);
    bus.btn_in = 8'h00;
    #2;
    rst = 1'b1;
    repeat (10) tick();
    check_eq("t6_post_req",   32'(bus.req_pending), 32'h00);
    check_eq("t6_post_valid", 32'(bus.tgt_valid),   32'h0);
    check_eq("t6_post_up",    32'(bus.dir_up),      32'h0);
    check_eq("t6_post_down",  32'(bus.dir_down),    32'h0);
    check_eq("t6_post_tgt",   32'(bus.tgt_floor),   32'h0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
Upstream request stage for the Elevator controller. Synchronises and debounces the eight floor call buttons (G, 1..7) and latches them as pending requests until served. Runs a SCAN-style direction FSM and presents one registered target floor to the controller, which reports its present floor and a served pulse.

Parameters:
NFLOORS, 8, number of floors; bit i = floor i, where G = floor 0.
FW, 3, floor index width.
DEB_CYCLES, 4, consecutive stable synchronised samples required before a debounced level change (>= 1).

Ports:
clk  input  1  system clock; all flops on the rising edge.
rst  input  1  asynchronous, active-low reset.
btn_in  input  NFLOORS  raw buttons; [0]=inG, [1]=in1 ... [7]=in7; asynchronous, may bounce.
cur_floor  input  FW  controller present floor (pfloor); synchronous to clk.
served  input  1  one-cycle pulse: controller has opened the doors at cur_floor.
req_pending  output  NFLOORS  latched pending requests.
tgt_floor  output  FW  next floor to serve (nfloor).
tgt_valid  output  1  tgt_floor is meaningful.
dir_up  output  1  FSM in UP.
dir_down  output  1  FSM in DOWN.

Behaviour:
- Reset (rst=0, asynchronous): sync flops, debounce counters, debounced levels, req_pending, tgt_floor, tgt_valid, dir_up and dir_down all go to 0, and the FSM goes to IDLE. These hold while rst=0.
  - Reset mid-operation discards all pending requests.
  - A button held through reset release is a new request, because the debounced level restarts at 0.
- Synchronisation: each btn_in bit passes through a 2-flop synchroniser.
- Debounce, per bit, with a counter of clog2(DEB_CYCLES+1) bits:
  - If the synchronised value differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEB_CYCLES, the debounced level toggles and the counter clears.
  - Pulses shorter than DEB_CYCLES synchronised samples are ignored.
- Request latch: a rising edge of a debounced level sets req_pending[i] on the same edge the level toggles.
  - Latency: btn_in[i] first sampled high at edge N (held steady) gives req_pending[i]=1 after edge N+1+DEB_CYCLES.
  - Falling debounced edges have no effect.
  - A set request stays set until served.
- Clear: served=1 clears req_pending[cur_floor] on the next edge.
  - Simultaneous set and clear of the same bit: clear wins.
  - Sets of other bits proceed normally in the same cycle.
- FSM states: IDLE, UP, DOWN. It is evaluated every cycle from the current req_pending (registered value) and cur_floor.
  - "above" = any pending at an index > cur_floor. "below" = any pending at an index < cur_floor. "here" = req_pending[cur_floor].
  - IDLE: above -> UP; else below -> DOWN; else stay IDLE. If above and below are both true, UP wins.
  - UP: stay while above or here. Else below -> DOWN. Else -> IDLE.
  - DOWN: stay while below or here. Else above -> UP. Else -> IDLE.
- Target selection is combinational from the next state. The outputs are registered, so they lag req_pending/cur_floor by one cycle.
  - UP: tgt_floor = lowest pending index >= cur_floor.
  - DOWN: tgt_floor = highest pending index <= cur_floor.
  - IDLE with here: tgt_floor = cur_floor, tgt_valid=1.
  - IDLE with nothing pending: tgt_valid=0 and tgt_floor holds its last value.
  - tgt_valid = (req_pending != 0), registered with the target.
- Direction flags: dir_up=(state==UP), dir_down=(state==DOWN). They are never both 1.
- A new request nearer in the current sweep direction retargets tgt_floor immediately; there is no commitment to the old target.
- Arithmetic: index comparisons are unsigned FW-bit. All cur_floor codes 0..7 are valid, with no wrap.

Test Plan:
1. DEB_CYCLES=4, cur_floor=0. btn_in=8'h04 held 12 cycles from edge N -> req_pending=8'h04 after edge N+5; one cycle later tgt_floor=2, tgt_valid=1, dir_up=1.
2. btn_in[5] high for 2 cycles, then low, repeated 3 times -> req_pending stays 8'h00 and tgt_valid stays 0.
3. cur_floor=3, requests 1 and 6 latched in the same cycle -> UP, tgt_floor=6.
   - Then cur_floor=6 with a served pulse -> req_pending=8'h02, DOWN, tgt_floor=1.
   - Then cur_floor=1 with a served pulse -> IDLE, tgt_valid=0, dir_up=dir_down=0.
4. UP, cur_floor=2, pending {5,7}, tgt_floor=5. Request 4 latches -> next cycle tgt_floor=4. Request 1 latched meanwhile -> no direction change until 4, 5 and 7 are served.
5. cur_floor=3, served pulse on the same edge that the floor-3 debounced level rises -> req_pending[3] remains 0.
6. Pending {2,6}, rst driven low between clock edges -> all outputs 0 immediately (asynchronous). After rst=1 with btn_in=0 -> outputs remain 0.
